// File: rtl/m_wb_ledctrl_if.sv
// ----------------------------------------------------------------------------
// m_wb_ledctrl_if
// Wishbone classic bus bundle between the midgetv core (master) and the
// LED/GPIO peripheral m_wb_ledctrl (slave).
//   CYC_I, STB_I, WE_I : cycle, strobe, write enable (master -> slave)
//   ADR_I[1:0]         : word select, core ADR_O[3:2]  (master -> slave)
//   DAT_I[31:0]        : write data                    (master -> slave)
//   DAT_O[31:0]        : read data, valid with ACK_O   (slave -> master)
//   ACK_O              : registered acknowledge        (slave -> master)
// ----------------------------------------------------------------------------
interface m_wb_ledctrl_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [1:0]  ADR_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/m_wb_ledctrl.sv
// ----------------------------------------------------------------------------
// m_wb_ledctrl
// Wishbone LED/GPIO output slave for midgetv board tops. NLED channels with
// static value, per-channel blink driven by a shared prescaler, and an
// optional global PWM dimmer.
//
// Register map (ADR_I): 0 OUT, 1 MODE (1 = blink), 2 PRESC (blink half-period
// minus 1), 3 DUTY (PWM duty). Reads are zero-extended to 32 bits.
//
// Build option: define LEDCTRL_PWM_EN to build DUTY, the PWM counter and the
// output gating; otherwise address 3 reads 0 and ignores writes.
//
// Ports:
//   CLK_I        : clock, rising edge
//   RST_NI       : asynchronous active-low reset
//   wb           : Wishbone slave modport (CYC/STB/WE/ADR/DAT_I in, DAT_O/ACK_O out)
//   corerunning  : core status input
//   led          : registered LED pins
//   led_run      : registered copy of corerunning
// ----------------------------------------------------------------------------
module m_wb_ledctrl #(
   parameter int unsigned NLED = 4,
   parameter int unsigned PW   = 24
) (
   input  logic            CLK_I,
   input  logic            RST_NI,
   m_wb_ledctrl_if.slave   wb,
   input  logic            corerunning,
   output logic [NLED-1:0] led,
   output logic            led_run
);

   logic [NLED-1:0] r_out;
   logic [NLED-1:0] r_mode;
   logic [PW-1:0]   r_presc;
   logic [PW-1:0]   r_pcnt;
   logic            r_phase;
   logic            r_ack;
   logic [31:0]     r_dat;
   logic [NLED-1:0] r_led;
   logic            r_led_run;

   logic            w_req;
   logic            w_wr;
   logic            w_presc_wr;
   logic            w_pwmon;
   logic [31:0]     w_rdata;
   logic [NLED-1:0] w_led_d;
   logic            w_unused;

`ifdef LEDCTRL_PWM_EN
   logic [7:0]      r_duty;
   logic [7:0]      r_pwmcnt;
`endif

   // ~ACK_O in the request term makes a held strobe commit only once.
   assign w_req      = wb.CYC_I & wb.STB_I & ~r_ack;
   assign w_wr       = w_req & wb.WE_I;
   assign w_presc_wr = w_wr & (wb.ADR_I == 2'd2);

   // Upper write-data bits are don't-care; fold them so nothing dangles.
   assign w_unused = ^wb.DAT_I;

   always_comb begin
      w_rdata = '0;
      case (wb.ADR_I)
         2'd0:    w_rdata = 32'(r_out);
         2'd1:    w_rdata = 32'(r_mode);
         2'd2:    w_rdata = 32'(r_presc);
`ifdef LEDCTRL_PWM_EN
         2'd3:    w_rdata = 32'(r_duty);
`endif
         default: w_rdata = '0;
      endcase
   end

   // Bus side: acknowledge, read data and OUT/MODE commits.
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         r_ack  <= 1'b0;
         r_dat  <= '0;
         r_out  <= '0;
         r_mode <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_req ? w_rdata : 32'd0;
         if (w_wr) begin
            case (wb.ADR_I)
               2'd0:    r_out  <= wb.DAT_I[NLED-1:0];
               2'd1:    r_mode <= wb.DAT_I[NLED-1:0];
               default: ;
            endcase
         end
      end
   end

   // Blink prescaler; a PRESC write restarts the low half-period and
   // overrides a coincident terminal count.
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         r_presc <= '1;
         r_pcnt  <= '0;
         r_phase <= 1'b0;
      end else if (w_presc_wr) begin
         r_presc <= wb.DAT_I[PW-1:0];
         r_pcnt  <= '0;
         r_phase <= 1'b0;
      end else if (r_pcnt == r_presc) begin
         r_pcnt  <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_pcnt  <= r_pcnt + PW'(1);
      end
   end

`ifdef LEDCTRL_PWM_EN
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         r_duty   <= 8'hFF;
         r_pwmcnt <= 8'd0;
      end else begin
         r_pwmcnt <= r_pwmcnt + 8'd1;
         if (w_wr && (wb.ADR_I == 2'd3)) begin
            r_duty <= wb.DAT_I[7:0];
         end
      end
   end

   // 255 is special-cased so full duty is truly always on.
   assign w_pwmon = (r_duty == 8'hFF) | (r_pwmcnt < r_duty);
`else
   assign w_pwmon = 1'b1;
`endif

   assign w_led_d = ((r_mode & r_out & {NLED{r_phase}}) | (~r_mode & r_out))
                    & {NLED{w_pwmon}};

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         r_led     <= '0;
         r_led_run <= 1'b0;
      end else begin
         r_led     <= w_led_d;
         r_led_run <= corerunning;
      end
   end

   assign wb.ACK_O = r_ack;
   assign wb.DAT_O = r_dat;
   assign led      = r_led;
   assign led_run  = r_led_run;

endmodule

// File: tb/tb_m_wb_ledctrl.sv
// ----------------------------------------------------------------------------
// tb_m_wb_ledctrl
// Directed bench for m_wb_ledctrl (NLED=4, PW=24). Inputs are driven on the
// falling edge, outputs sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_m_wb_ledctrl;

   logic        clk;
   logic        rst_n;
   logic        corerunning;
   logic [3:0]  led;
   logic        led_run;
   logic [31:0] rd;
   int          n_checks;
   int          n_err;
   int          hi_cnt;

   m_wb_ledctrl_if wb ();

   m_wb_ledctrl #(
      .NLED (4),
      .PW   (24)
   ) u_dut (
      .CLK_I       (clk),
      .RST_NI      (rst_n),
      .wb          (wb.slave),
      .corerunning (corerunning),
      .led         (led),
      .led_run     (led_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One single-beat transaction; commit happens at the rising edge inside.
   task automatic bus_req(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                          output logic [31:0] rdata);
      @(negedge clk);
      wb.CYC_I = 1'b1;
      wb.STB_I = 1'b1;
      wb.WE_I  = we;
      wb.ADR_I = adr;
      wb.DAT_I = dat;
      @(posedge clk);
      #1;
      chk("ack_on_req", 32'(wb.ACK_O), 32'd1);
      rdata = wb.DAT_O;
      @(negedge clk);
      wb.CYC_I = 1'b0;
      wb.STB_I = 1'b0;
      wb.WE_I  = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      corerunning = 1'b0;
      wb.CYC_I    = 1'b0;
      wb.STB_I    = 1'b0;
      wb.WE_I     = 1'b0;
      wb.ADR_I    = 2'd0;
      wb.DAT_I    = 32'd0;

      // Reset state
      #12;
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_led_run", 32'(led_run), 32'd0);
      chk("rst_ack", 32'(wb.ACK_O), 32'd0);
      chk("rst_dat", wb.DAT_O, 32'd0);
      corerunning = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      bus_req(1'b0, 2'd2, 32'd0, rd);
      chk("rd_presc_rst", rd, 32'h00FF_FFFF);
      @(posedge clk);
      #1;
      chk("ack_drop", 32'(wb.ACK_O), 32'd0);
      chk("dat_idle", wb.DAT_O, 32'd0);
      chk("led_run_on", 32'(led_run), 32'd1);

      // Write OUT=5 with the strobe held across two edges: one ack only
      @(negedge clk);
      wb.CYC_I = 1'b1;
      wb.STB_I = 1'b1;
      wb.WE_I  = 1'b1;
      wb.ADR_I = 2'd0;
      wb.DAT_I = 32'h5;
      @(posedge clk);
      #1;
      chk("hold_ack1", 32'(wb.ACK_O), 32'd1);
      chk("hold_led_pre", 32'(led), 32'd0);
      @(posedge clk);
      #1;
      chk("hold_ack2", 32'(wb.ACK_O), 32'd0);
      chk("hold_led_post", 32'(led), 32'h5);
      @(negedge clk);
      wb.CYC_I = 1'b0;
      wb.STB_I = 1'b0;
      wb.WE_I  = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_ack3", 32'(wb.ACK_O), 32'd0);

      bus_req(1'b0, 2'd0, 32'd0, rd);
      chk("rd_out", rd, 32'h5);
      bus_req(1'b0, 2'd1, 32'd0, rd);
      chk("rd_mode", rd, 32'h0);

`ifndef LEDCTRL_PWM_EN
      // DUTY absent: write is acknowledged and dropped
      bus_req(1'b1, 2'd3, 32'h40, rd);
      bus_req(1'b0, 2'd3, 32'd0, rd);
      chk("rd_duty_off", rd, 32'h0);
      chk("led_pwm_off", 32'(led), 32'h5);
`endif

      // Upper data bits ignored
      bus_req(1'b1, 2'd0, 32'hFFFF_FFFA, rd);
      bus_req(1'b0, 2'd0, 32'd0, rd);
      chk("rd_out_trunc", rd, 32'h0000_000A);

      // Blink on channel 0 with PRESC=2
      bus_req(1'b1, 2'd0, 32'h1, rd);
      bus_req(1'b1, 2'd1, 32'h1, rd);
      bus_req(1'b1, 2'd2, 32'h2, rd);
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         chk("blink", 32'(led), (((i - 1) / 3) % 2 == 1) ? 32'h1 : 32'h0);
      end
      // Two more edges, then a PRESC write lands on the terminal count
      @(posedge clk);
      @(posedge clk);
      bus_req(1'b1, 2'd2, 32'h2, rd);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         chk("blink_restart", 32'(led), (i > 3) ? 32'h1 : 32'h0);
      end

`ifdef LEDCTRL_PWM_EN
      bus_req(1'b1, 2'd1, 32'h0, rd);
      bus_req(1'b1, 2'd0, 32'hF, rd);
      bus_req(1'b1, 2'd3, 32'd64, rd);
      hi_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #1;
         if (led[0]) hi_cnt++;
      end
      chk("pwm_64", 32'(hi_cnt), 32'd64);
      bus_req(1'b1, 2'd3, 32'd0, rd);
      hi_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #1;
         if (led != 4'h0) hi_cnt++;
      end
      chk("pwm_0", 32'(hi_cnt), 32'd0);
      bus_req(1'b1, 2'd3, 32'd255, rd);
      hi_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #1;
         if (led == 4'hF) hi_cnt++;
      end
      chk("pwm_255", 32'(hi_cnt), 32'd256);
`else
      bus_req(1'b1, 2'd1, 32'h0, rd);
      @(posedge clk);
      #1;
      chk("led_static", 32'(led), 32'h1);
`endif

      // Reset asserted inside the request cycle of OUT=0xF
      @(negedge clk);
      wb.CYC_I = 1'b1;
      wb.STB_I = 1'b1;
      wb.WE_I  = 1'b1;
      wb.ADR_I = 2'd0;
      wb.DAT_I = 32'hF;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_led", 32'(led), 32'd0);
      chk("arst_led_run", 32'(led_run), 32'd0);
      chk("arst_ack", 32'(wb.ACK_O), 32'd0);
      @(posedge clk);
      #1;
      chk("arst_ack_edge", 32'(wb.ACK_O), 32'd0);
      @(negedge clk);
      wb.CYC_I = 1'b0;
      wb.STB_I = 1'b0;
      wb.WE_I  = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rel_led_run", 32'(led_run), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_led_run_follow", 32'(led_run), 32'd1);
      @(negedge clk);
      corerunning = 1'b0;
      @(posedge clk);
      #1;
      chk("led_run_off", 32'(led_run), 32'd0);
      bus_req(1'b0, 2'd0, 32'd0, rd);
      chk("rd_out_after_rst", rd, 32'h0);
      bus_req(1'b0, 2'd2, 32'd0, rd);
      chk("rd_presc_after_rst", rd, 32'h00FF_FFFF);
      chk("led_after_rst", 32'(led), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
